// File: rtl/writeback_unit.sv
// Integer register-bank write port: arbitrates load responses, a 1-entry ALU skid
// buffer and new ALU results, extracts/extends load data and flags RAW hazards.
// Optional WB_TRACE_EN enables simulation trace prints of writes and load anomalies.
module writeback_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_offset,
  output logic        ld_ready,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard,
  output logic        ld_timeout,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data,
  output logic        reg_write
);
  typedef enum logic {IDLE, LD_WAIT} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [4:0]    lat_rd;
  logic [2:0]    lat_f3, lat_off;
  logic [CW-1:0] cnt;
  logic          skid_valid;
  logic [4:0]    skid_rd;
  logic [63:0]   skid_data;

  logic          ld_fire, alu_acc, abort, win_valid, skid_fill, skid_drain;
  logic [4:0]    win_rd;
  logic [63:0]   win_data;

  function automatic logic [63:0] extract(input logic [2:0] f3, input logic [2:0] off,
                                          input logic [63:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = d[{off[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  extract = {{56{b[7]}}, b};
      3'b100:  extract = {56'b0, b};
      3'b001:  extract = {{48{h[15]}}, h};
      3'b101:  extract = {48'b0, h};
      3'b010:  extract = {{32{w[31]}}, w};
      3'b110:  extract = {32'b0, w};
      default: extract = d;
    endcase
  endfunction

  function automatic logic src_hit(input logic [4:0] x);
    src_hit = (x != 5'd0) && ((x == rs1_addr) || (x == rs2_addr));
  endfunction

  assign ld_ready  = (state == IDLE);
  assign alu_ready = !skid_valid;
  assign alu_acc   = alu_valid && !skid_valid;
  assign ld_fire   = (state == LD_WAIT) && mem_rsp_valid;
  // Abort on the edge where the wait counter would reach TIMEOUT-1.
  assign abort     = (TIMEOUT != 0) && (32'(cnt) + 32'd1 >= 32'(TIMEOUT) - 32'd1);

  assign hazard = ((state == LD_WAIT) && src_hit(lat_rd)) ||
                  (skid_valid && src_hit(skid_rd)) ||
                  (reg_write && src_hit(rd_addr));

  always_comb begin
    state_nxt  = state;
    win_valid  = 1'b0;
    win_rd     = 5'd0;
    win_data   = 64'd0;
    skid_fill  = 1'b0;
    skid_drain = 1'b0;
    case (state)
      IDLE:    if (ld_issue) state_nxt = LD_WAIT;
      LD_WAIT: if (mem_rsp_valid || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ld_fire) begin
      win_valid = 1'b1;
      win_rd    = lat_rd;
      win_data  = extract(lat_f3, lat_off, mem_rsp_data);
      skid_fill = alu_acc;
    end else if (skid_valid) begin
      win_valid  = 1'b1;
      win_rd     = skid_rd;
      win_data   = skid_data;
      skid_drain = 1'b1;
    end else if (alu_acc) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      skid_valid <= 1'b0;
      ld_timeout <= 1'b0;
      rd_addr    <= 5'd0;
      rd_data    <= 64'd0;
      reg_write  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ld_timeout <= (state == LD_WAIT) && !mem_rsp_valid && abort;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + CW'(1);
      if (skid_fill)       skid_valid <= 1'b1;
      else if (skid_drain) skid_valid <= 1'b0;
      // rd==0 consumes its source but leaves the visible write port untouched.
      reg_write <= win_valid && (win_rd != 5'd0);
      if (win_valid && (win_rd != 5'd0)) begin
        rd_addr <= win_rd;
        rd_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && ld_issue) begin
      lat_rd  <= ld_rd;
      lat_f3  <= ld_funct3;
      lat_off <= ld_offset;
    end
    if (skid_fill) begin
      skid_rd   <= alu_rd;
      skid_data <= alu_data;
    end
  end

`ifdef WB_TRACE_EN
  logic wb_from_load;
  always_ff @(posedge clk) begin
    wb_from_load <= ld_fire;
    if (reg_write)
      $display("WB: x%0d = %h (%s)", rd_addr, rd_data, wb_from_load ? "LOAD" : "ALU");
    if (!rst && state == IDLE && mem_rsp_valid)
      $display("WB warning: memory response with no load pending");
    if (ld_timeout)
      $display("WB warning: load timed out, no write performed");
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares them (register, data and cycle).
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3, ld_offset;
  logic        ld_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        hazard, ld_timeout, reg_write;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  writeback_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_offset(ld_offset),
    .ld_ready(ld_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard), .ld_timeout(ld_timeout),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && reg_write === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write (cycle %0d)",
                 rd_addr, rd_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rd_addr !== e.rd || rd_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write: got x%0d=%h at cycle %0d expected x%0d=%h at cycle %0d",
                   rd_addr, rd_data, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data, input int lat);
    q.push_back('{rd: rd, data: data, cyc: cyc + lat});
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] rsp, input logic [63:0] exp);
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_offset = off;
    step();
    ld_issue = 1'b0;
    chk("ld_ready_wait", {63'b0, ld_ready}, 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
    if (rd != 5'd0) expect_wr(rd, exp, 1);
    step();
    mem_rsp_valid = 1'b0;
    chk("ld_ready_idle", {63'b0, ld_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'd0; ld_offset = 3'd0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    step(); step();
    rst = 1'b0;
    chk("rst_reg_write", {63'b0, reg_write}, 64'd0);
    chk("rst_rd_addr", {59'b0, rd_addr}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_ld_timeout", {63'b0, ld_timeout}, 64'd0);
    chk("rst_ld_ready", {63'b0, ld_ready}, 64'd1);
    chk("rst_alu_ready", {63'b0, alu_ready}, 64'd1);

    // Plain ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    chk("alu_ready_offer", {63'b0, alu_ready}, 64'd1);
    expect_wr(5'd5, 64'h1234, 1);
    step();
    alu_valid = 1'b0;
    chk("alu_ready_after", {63'b0, alu_ready}, 64'd1);

    // ALU to x0: consumed, no write, rd_data keeps 0x1234
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hAA;
    step();
    alu_valid = 1'b0;
    chk("x0_no_write", {63'b0, reg_write}, 64'd0);
    chk("x0_rd_data_kept", rd_data, 64'h1234);

    // Load extraction
    do_load(5'd10, 3'b000, 3'd3, 64'h00000000_80FF7F00, 64'hFFFFFFFF_FFFFFF80);
    do_load(5'd10, 3'b100, 3'd3, 64'h00000000_80FF7F00, 64'h00000000_00000080);
    do_load(5'd11, 3'b110, 3'd4, 64'hDEADBEEF_00000001, 64'h00000000_DEADBEEF);
    do_load(5'd12, 3'b001, 3'd3, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001);
    do_load(5'd12, 3'b101, 3'd2, 64'h00000000_80010000, 64'h00000000_00008001);
    do_load(5'd13, 3'b010, 3'd1, 64'h12345678_80000000, 64'hFFFFFFFF_80000000);
    do_load(5'd14, 3'b011, 3'd5, 64'hCAFEF00D_12345678, 64'hCAFEF00D_12345678);
    do_load(5'd15, 3'b111, 3'd0, 64'h01020304_05060708, 64'h01020304_05060708);

    // Load response and ALU result collide
    ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b011; ld_offset = 3'd0;
    step();
    ld_issue = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h77;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h55;
    expect_wr(5'd7, 64'h77, 1);
    expect_wr(5'd8, 64'h55, 2);
    step();
    mem_rsp_valid = 1'b0; alu_valid = 1'b0;
    chk("skid_alu_ready_low", {63'b0, alu_ready}, 64'd0);
    step();
    chk("skid_alu_ready_back", {63'b0, alu_ready}, 64'd1);

    // Hazard tracking on a pending load to x9
    rs1_addr = 5'd9;
    ld_issue = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b011;
    step();
    ld_issue = 1'b0;
    chk("hz_pending1", {63'b0, hazard}, 64'd1);
    step();
    chk("hz_pending2", {63'b0, hazard}, 64'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h99;
    expect_wr(5'd9, 64'h99, 1);
    step();
    mem_rsp_valid = 1'b0;
    chk("hz_write_cycle", {63'b0, hazard}, 64'd1);
    step();
    chk("hz_cleared", {63'b0, hazard}, 64'd0);
    rs1_addr = 5'd0;
    ld_issue = 1'b1; ld_rd = 5'd0;
    step();
    ld_issue = 1'b0;
    chk("hz_x0", {63'b0, hazard}, 64'd0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("ld_x0_no_write", {63'b0, reg_write}, 64'd0);

    // Timeout with TIMEOUT=4: pulse four cycles after issue
    ld_issue = 1'b1; ld_rd = 5'd11;
    step();
    ld_issue = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("to_not_yet", {63'b0, ld_timeout}, 64'd0);
      step();
    end
    chk("to_pulse", {63'b0, ld_timeout}, 64'd1);
    chk("to_ld_ready", {63'b0, ld_ready}, 64'd1);
    chk("to_no_write", {63'b0, reg_write}, 64'd0);
    step();
    chk("to_pulse_end", {63'b0, ld_timeout}, 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD;
    step();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", {63'b0, reg_write}, 64'd0);

    // Reset while a load is pending, then a stale response
    ld_issue = 1'b1; ld_rd = 5'd12;
    step();
    ld_issue = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hF00;
    step();
    mem_rsp_valid = 1'b0;
    chk("rstld_reg_write", {63'b0, reg_write}, 64'd0);
    chk("rstld_rd_addr", {59'b0, rd_addr}, 64'd0);
    chk("rstld_rd_data", rd_data, 64'd0);
    chk("rstld_ld_ready", {63'b0, ld_ready}, 64'd1);
    chk("rstld_ld_timeout", {63'b0, ld_timeout}, 64'd0);

    step(); step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
